// File: rtl/iomem_gpio.sv
// iomem_gpio: parametrised GPIO peripheral for the picosoc iomem bus.
// Per-pin OUT/OE registers, 2-FF synchronised inputs, edge-detect
// interrupts with sticky W1C status and a level irq output.
// Defining GPIO_PWM_EN adds 8-bit PWM on the low PWM_CH channels
// (PWM_EN at 0x18, DUTY[i] at 0x20+4*i). Without it those offsets read 0.
module iomem_gpio #(
    parameter int unsigned WIDTH     = 8,
    parameter logic [7:0]  BASE_ADDR = 8'h03,
    parameter int unsigned PWM_CH    = 4,
    parameter int unsigned PWM_DIV   = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    input  logic [WIDTH-1:0] gpio_in,
    output logic             irq
);

    // Word indices (iomem_addr[7:2]) of the register map
    localparam logic [5:0] REG_OUT      = 6'h00;
    localparam logic [5:0] REG_OE       = 6'h01;
    localparam logic [5:0] REG_IN       = 6'h02;
    localparam logic [5:0] REG_IRQ_EN   = 6'h03;
    localparam logic [5:0] REG_IRQ_EDGE = 6'h04;
    localparam logic [5:0] REG_IRQ_STAT = 6'h05;
`ifdef GPIO_PWM_EN
    localparam logic [5:0] REG_PWM_EN   = 6'h06;
    localparam logic [5:0] REG_DUTY0    = 6'h08;
    localparam int unsigned PRE_W       = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
`endif

    // Bus-side state
    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q, irq_d;

    // Pin registers
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] oe_q, oe_d;
    logic [WIDTH-1:0] irq_en_q, irq_en_d;
    logic [WIDTH-1:0] irq_edge_q, irq_edge_d;
    logic [WIDTH-1:0] irq_stat_q, irq_stat_d;

    // Input synchroniser and edge history
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    // Decode helpers
    logic             sel;
    logic             wr;
    logic [5:0]       word;
    logic [31:0]      bmask;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wval;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_val;

`ifdef GPIO_PWM_EN
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [PWM_CH-1:0] pwm_en_q, pwm_en_d;
    logic [7:0]        duty_q [PWM_CH];
    logic [7:0]        duty_d [PWM_CH];
`endif

    // Byte-lane merge restricted to the implemented pin bits
    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_v,
                                               input logic [WIDTH-1:0] new_v,
                                               input logic [WIDTH-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    // Address decode, byte masks and edge detection
    always_comb begin
        sel   = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE_ADDR);
        wr    = sel && (iomem_wstrb != 4'b0000);
        word  = iomem_addr[7:2];
        bmask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                 {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
        wmask = bmask[WIDTH-1:0];
        wval  = iomem_wdata[WIDTH-1:0];
        rise  = sync2_q & ~prev_q;
        fall  = ~sync2_q & prev_q;
        evt   = irq_en_q & ((irq_edge_q & rise) | (~irq_edge_q & fall));
        clr   = (wr && word == REG_IRQ_STAT) ? (wval & wmask) : '0;
    end

    // Read mux: returns register contents before any same-access write
    always_comb begin
        rd_val = 32'd0;
        case (word)
            REG_OUT:      rd_val = 32'(out_q);
            REG_OE:       rd_val = 32'(oe_q);
            REG_IN:       rd_val = 32'(sync2_q);
            REG_IRQ_EN:   rd_val = 32'(irq_en_q);
            REG_IRQ_EDGE: rd_val = 32'(irq_edge_q);
            REG_IRQ_STAT: rd_val = 32'(irq_stat_q);
`ifdef GPIO_PWM_EN
            REG_PWM_EN:   rd_val = 32'(pwm_en_q);
`endif
            default: begin
`ifdef GPIO_PWM_EN
                for (int i = 0; i < PWM_CH; i++) begin
                    if (word == REG_DUTY0 + 6'(i)) rd_val = 32'(duty_q[i]);
                end
`endif
            end
        endcase
    end

    // Next-state for bus handshake, pin registers, synchroniser and status
    always_comb begin
        ready_d    = sel;
        rdata_d    = sel ? rd_val : rdata_q;
        irq_d      = |irq_stat_q;
        out_d      = out_q;
        oe_d       = oe_q;
        irq_en_d   = irq_en_q;
        irq_edge_d = irq_edge_q;
        sync1_d    = gpio_in;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        if (wr && word == REG_OUT)      out_d      = merge(out_q, wval, wmask);
        if (wr && word == REG_OE)       oe_d       = merge(oe_q, wval, wmask);
        if (wr && word == REG_IRQ_EN)   irq_en_d   = merge(irq_en_q, wval, wmask);
        if (wr && word == REG_IRQ_EDGE) irq_edge_d = merge(irq_edge_q, wval, wmask);
        // A new event on the same bit beats a simultaneous W1C
        irq_stat_d = (irq_stat_q & ~clr) | evt;
    end

    // Register state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready_q    <= 1'b0;
            rdata_q    <= 32'd0;
            irq_q      <= 1'b0;
            out_q      <= '0;
            oe_q       <= '0;
            irq_en_q   <= '0;
            irq_edge_q <= '0;
            irq_stat_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
        end else begin
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
            out_q      <= out_d;
            oe_q       <= oe_d;
            irq_en_q   <= irq_en_d;
            irq_edge_q <= irq_edge_d;
            irq_stat_q <= irq_stat_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
        end
    end

`ifdef GPIO_PWM_EN
    // PWM prescaler, step counter and PWM_EN/DUTY register writes
    always_comb begin
        pre_d    = pre_q;
        cnt_d    = cnt_q;
        pwm_en_d = pwm_en_q;
        for (int i = 0; i < PWM_CH; i++) duty_d[i] = duty_q[i];
        if (pre_q == PRE_W'(PWM_DIV - 1)) begin
            pre_d = '0;
            cnt_d = cnt_q + 8'd1;
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
        if (wr && word == REG_PWM_EN) begin
            pwm_en_d = (pwm_en_q & ~bmask[PWM_CH-1:0]) |
                       (iomem_wdata[PWM_CH-1:0] & bmask[PWM_CH-1:0]);
        end
        for (int i = 0; i < PWM_CH; i++) begin
            if (wr && word == REG_DUTY0 + 6'(i) && iomem_wstrb[0]) duty_d[i] = iomem_wdata[7:0];
        end
    end

    // PWM state registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pre_q    <= '0;
            cnt_q    <= 8'd0;
            pwm_en_q <= '0;
            for (int i = 0; i < PWM_CH; i++) duty_q[i] <= 8'd0;
        end else begin
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            pwm_en_q <= pwm_en_d;
            for (int i = 0; i < PWM_CH; i++) duty_q[i] <= duty_d[i];
        end
    end

    // Pin output: PWM waveform on enabled low channels, OUT elsewhere
    always_comb begin
        gpio_out = out_q;
        for (int i = 0; i < PWM_CH; i++) begin
            if (pwm_en_q[i]) gpio_out[i] = (cnt_q < duty_q[i]);
        end
    end
`else
    // Pin output straight from OUT
    assign gpio_out = out_q;

    // PWM configuration has no effect in this build
    logic unused_pwm_cfg;
    assign unused_pwm_cfg = ^{32'(PWM_CH), 32'(PWM_DIV)};
`endif

    assign gpio_oe     = oe_q;
    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign irq         = irq_q;

    // Address bits outside the decode and write-data bits above WIDTH are don't-care
    logic unused_bus_bits;
    assign unused_bus_bits = ^{iomem_addr[23:8], iomem_addr[1:0], iomem_wdata, bmask};

endmodule

// File: tb/tb_iomem_gpio.sv
// tb_iomem_gpio: directed self-checking bench for iomem_gpio (WIDTH=8).
// Covers the PWM channel when built with GPIO_PWM_EN.
module tb_iomem_gpio;

    logic        clk = 1'b0;
    logic        resetn;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic [7:0]  gpio_in;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    iomem_gpio #(
        .WIDTH(8),
        .BASE_ADDR(8'h03),
        .PWM_CH(4),
        .PWM_DIV(1)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .iomem_valid(iomem_valid),
        .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata),
        .gpio_out(gpio_out),
        .gpio_oe(gpio_oe),
        .gpio_in(gpio_in),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus access; checks the one-cycle ready pulse and returns rdata
    task automatic bus(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, output logic [31:0] rd);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wdata = wdata;
        iomem_wstrb = wstrb;
        check({tag, "/ready_pre"}, 32'(iomem_ready), 32'd0);
        tick();
        check({tag, "/ready"}, 32'(iomem_ready), 32'd1);
        rd = iomem_rdata;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        tick();
        check({tag, "/ready_drop"}, 32'(iomem_ready), 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        bus(tag, addr, 32'd0, 4'b0000, rd);
        check({tag, "/rdata"}, rd, exp);
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] wstrb);
        logic [31:0] rd;
        bus(tag, addr, data, wstrb, rd);
    endtask

    task automatic pwm_count(output int n);
        n = 0;
        repeat (256) begin
            tick();
            if (gpio_out[0]) n++;
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          hi;

        resetn      = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        iomem_addr  = 32'd0;
        iomem_wdata = 32'd0;
        gpio_in     = 8'h00;
        repeat (3) tick();
        resetn = 1'b1;
        tick();

        // Reset state
        check("rst/ready", 32'(iomem_ready), 32'd0);
        check("rst/rdata", iomem_rdata, 32'd0);
        check("rst/irq", 32'(irq), 32'd0);
        check("rst/gpio_out", 32'(gpio_out), 32'd0);
        check("rst/gpio_oe", 32'(gpio_oe), 32'd0);

        // Reads after reset
        rd_chk("t1/out", 32'h0300_0000, 32'd0);
        rd_chk("t1/oe", 32'h0300_0004, 32'd0);
        rd_chk("t1/stat", 32'h0300_0014, 32'd0);
        check("t1/irq", 32'(irq), 32'd0);

        // Byte strobes and bits above WIDTH
        wr("t2/w_out_b0", 32'h0300_0000, 32'hFFFF_FFA5, 4'b0001);
        check("t2/gpio_out", 32'(gpio_out), 32'h0000_00A5);
        rd_chk("t2/r_out", 32'h0300_0000, 32'h0000_00A5);
        wr("t2/w_out_b1", 32'h0300_0000, 32'h0000_5A00, 4'b0010);
        check("t2/gpio_out_b1", 32'(gpio_out), 32'h0000_00A5);
        rd_chk("t2/r_out_b1", 32'h0300_0000, 32'h0000_00A5);
        wr("t2/w_oe", 32'h0300_0004, 32'h0000_003C, 4'b1111);
        check("t2/gpio_oe", 32'(gpio_oe), 32'h0000_003C);
        rd_chk("t2/r_oe", 32'h0300_0004, 32'h0000_003C);
        tick();
        tick();
        check("t2/rdata_hold", iomem_rdata, 32'h0000_003C);
        wr("t2/w_in", 32'h0300_0008, 32'h0000_00FF, 4'b1111);
        rd_chk("t2/r_in", 32'h0300_0008, 32'd0);

        // Rising-edge interrupt on bit 0 and its latency
        wr("t3/w_en", 32'h0300_000C, 32'h0000_0001, 4'b1111);
        wr("t3/w_edge", 32'h0300_0010, 32'h0000_0001, 4'b1111);
        gpio_in = 8'h01;
        repeat (3) tick();
        check("t3/irq_c3", 32'(irq), 32'd0);
        tick();
        check("t3/irq_c4", 32'(irq), 32'd1);
        rd_chk("t3/r_in", 32'h0300_0008, 32'h0000_0001);
        rd_chk("t3/r_stat", 32'h0300_0014, 32'h0000_0001);
        bus("t3/w1c", 32'h0300_0014, 32'h0000_0001, 4'b1111, rd);
        check("t3/w1c_pre", rd, 32'h0000_0001);
        check("t3/irq_clr", 32'(irq), 32'd0);
        rd_chk("t3/r_stat_clr", 32'h0300_0014, 32'd0);
        gpio_in = 8'h00;
        repeat (5) tick();
        rd_chk("t3/r_stat_fall", 32'h0300_0014, 32'd0);
        check("t3/irq_fall", 32'(irq), 32'd0);

        // Falling-edge interrupt on bit 1; disabling does not clear status
        wr("t3/w_en3", 32'h0300_000C, 32'h0000_0003, 4'b1111);
        gpio_in = 8'h02;
        repeat (5) tick();
        rd_chk("t3/r_stat_b1r", 32'h0300_0014, 32'd0);
        gpio_in = 8'h00;
        repeat (5) tick();
        rd_chk("t3/r_stat_b1f", 32'h0300_0014, 32'h0000_0002);
        check("t3/irq_b1", 32'(irq), 32'd1);
        wr("t3/w_en0", 32'h0300_000C, 32'h0000_0000, 4'b1111);
        rd_chk("t3/r_stat_en0", 32'h0300_0014, 32'h0000_0002);
        wr("t3/w1c_b1", 32'h0300_0014, 32'h0000_0002, 4'b1111);
        rd_chk("t3/r_stat_b1c", 32'h0300_0014, 32'd0);

        // Event and W1C on the same bit in the same cycle
        wr("t4/w_en", 32'h0300_000C, 32'h0000_0001, 4'b1111);
        gpio_in = 8'h01;
        repeat (5) tick();
        gpio_in = 8'h00;
        repeat (5) tick();
        rd_chk("t4/r_stat_pre", 32'h0300_0014, 32'h0000_0001);
        gpio_in = 8'h01;
        tick();
        tick();
        bus("t4/w1c_race", 32'h0300_0014, 32'h0000_0001, 4'b1111, rd);
        check("t4/w1c_race_pre", rd, 32'h0000_0001);
        rd_chk("t4/r_stat_race", 32'h0300_0014, 32'h0000_0001);
        wr("t4/w1c", 32'h0300_0014, 32'h0000_0001, 4'b1111);
        rd_chk("t4/r_stat_clr", 32'h0300_0014, 32'd0);

        // Unmapped offset
        rd_chk("t4/r_unmapped", 32'h0300_003C, 32'd0);
        wr("t4/w_unmapped", 32'h0300_003C, 32'hFFFF_FFFF, 4'b1111);
        rd_chk("t4/r_out_keep", 32'h0300_0000, 32'h0000_00A5);

        // Foreign base address is ignored
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0400_0000;
        iomem_wstrb = 4'b0000;
        tick();
        check("t5/foreign_ready1", 32'(iomem_ready), 32'd0);
        tick();
        check("t5/foreign_ready2", 32'(iomem_ready), 32'd0);
        check("t5/foreign_rdata", iomem_rdata, 32'h0000_00A5);
        iomem_valid = 1'b0;
        tick();

        // Reset during an acknowledged access
        wr("t5/w_edge_fall", 32'h0300_0010, 32'h0000_0000, 4'b1111);
        gpio_in = 8'h00;
        repeat (5) tick();
        check("t5/irq_pre", 32'(irq), 32'd1);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_0000;
        iomem_wstrb = 4'b0000;
        tick();
        check("t5/ack_ready", 32'(iomem_ready), 32'd1);
        check("t5/ack_rdata", iomem_rdata, 32'h0000_00A5);
        resetn      = 1'b0;
        iomem_valid = 1'b0;
        tick();
        check("t5/rst_ready", 32'(iomem_ready), 32'd0);
        check("t5/rst_rdata", iomem_rdata, 32'd0);
        check("t5/rst_irq", 32'(irq), 32'd0);
        check("t5/rst_gpio_out", 32'(gpio_out), 32'd0);
        check("t5/rst_gpio_oe", 32'(gpio_oe), 32'd0);
        resetn = 1'b1;
        tick();
        rd_chk("t5/r_out", 32'h0300_0000, 32'd0);
        rd_chk("t5/r_oe", 32'h0300_0004, 32'd0);
        rd_chk("t5/r_en", 32'h0300_000C, 32'd0);
        rd_chk("t5/r_edge", 32'h0300_0010, 32'd0);
        rd_chk("t5/r_stat", 32'h0300_0014, 32'd0);
        check("t5/irq_post", 32'(irq), 32'd0);

`ifdef GPIO_PWM_EN
        // PWM on channel 0 with one counter step per clock
        wr("t6/w_oe", 32'h0300_0004, 32'h0000_000F, 4'b1111);
        wr("t6/w_duty64", 32'h0300_0020, 32'h0000_0040, 4'b0001);
        wr("t6/w_pwm_en", 32'h0300_0018, 32'h0000_0001, 4'b1111);
        rd_chk("t6/r_duty", 32'h0300_0020, 32'h0000_0040);
        rd_chk("t6/r_pwm_en", 32'h0300_0018, 32'h0000_0001);
        pwm_count(hi);
        check("t6/high_64", 32'(hi), 32'd64);
        check("t6/gpio_oe", 32'(gpio_oe), 32'h0000_000F);
        wr("t6/w_duty0", 32'h0300_0020, 32'h0000_0000, 4'b0001);
        pwm_count(hi);
        check("t6/high_0", 32'(hi), 32'd0);
        wr("t6/w_duty255", 32'h0300_0020, 32'h0000_00FF, 4'b0001);
        pwm_count(hi);
        check("t6/high_255", 32'(hi), 32'd255);
        wr("t6/w_out1", 32'h0300_0000, 32'h0000_0001, 4'b1111);
        wr("t6/w_pwm_off", 32'h0300_0018, 32'h0000_0000, 4'b1111);
        pwm_count(hi);
        check("t6/high_out", 32'(hi), 32'd256);
        rd_chk("t6/r_pwm_off", 32'h0300_0018, 32'd0);
`else
        // PWM offsets are inert without the feature
        wr("t6/w_pwm_en", 32'h0300_0018, 32'h0000_0001, 4'b1111);
        rd_chk("t6/r_pwm_en", 32'h0300_0018, 32'd0);
        wr("t6/w_duty", 32'h0300_0020, 32'h0000_0040, 4'b0001);
        rd_chk("t6/r_duty", 32'h0300_0020, 32'd0);
        wr("t6/w_out1", 32'h0300_0000, 32'h0000_0001, 4'b1111);
        check("t6/gpio_out", 32'(gpio_out), 32'h0000_0001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
